// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory access controller between the MEM stage and a handshaked RAM
// Optional misaligned-access trap enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_dout,
    output logic [31:0]       mem_din,
    output logic              mem_stall,
    output logic              mem_err,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       din_q, din_d;
    logic              err_q, err_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              req;
    logic              misalign;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    assign req = mem_ren | mem_wen;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = (mem_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        err_d   = err_q;
        cs_d    = 1'b0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    // ren and wen together resolve to a write but still flag an error
                    err_d = err_q | (mem_ren & mem_wen);
                    if (misalign) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        if (!mem_wen) begin
                            din_d = 32'd0;
                        end
                    end else begin
                        state_d = S_REQ;
                        cs_d    = 1'b1;
                        we_d    = mem_wen;
                        addr_d  = mem_addr[ADDR_W+1:2];
                        wdata_d = mem_dout;
                    end
                end
            end
            S_REQ: begin
                if (ram_ack) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        din_d = ram_rdata;
                    end
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (ram_ack) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        din_d = ram_rdata;
                    end
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    din_d   = TIMEOUT_DATA;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            din_q   <= 32'd0;
            err_q   <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            err_q   <= err_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Stall is forced low during reset so the pipeline is never frozen by an abandoned access
    assign mem_stall = rst_n & (((state_q == S_IDLE) & req) |
                                (state_q == S_REQ) | (state_q == S_WAIT));
    assign mem_din   = din_q;
    assign mem_err   = err_q;
    assign ram_cs    = cs_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - randomized self-checking bench for dmem_ctrl against a transaction-level model
module tb_dmem_ctrl;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_ren = 1'b0;
    logic              mem_wen = 1'b0;
    logic [31:0]       mem_addr = 32'd0;
    logic [31:0]       mem_dout = 32'd0;
    logic [31:0]       mem_din;
    logic              mem_stall;
    logic              mem_err;
    logic              ram_cs;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'd0;
    logic              ram_ack = 1'b0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_stall(mem_stall), .mem_err(mem_err), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expected architectural state
    logic [31:0] m_din = 32'd0;
    logic        m_err = 1'b0;

    // observations of the most recent access
    int                o_stall, o_cs, o_cs_cyc;
    logic [ADDR_W-1:0] o_addr, o_addr_done;
    logic              o_we, o_err, o_timed_out;
    logic [31:0]       o_wdata, o_din;

    // Acts as the pipeline and as a RAM that acks 'delay' cycles after its cs pulse.
    task automatic drive_access(input logic ren, input logic wen, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int delay, input bit hold);
        int waitn;
        bit done;
        waitn = -1; done = 0;
        o_stall = 0; o_cs = 0; o_cs_cyc = -1; o_addr = '0; o_we = 1'b0; o_wdata = 32'd0;
        o_din = 32'd0; o_err = 1'b0; o_addr_done = '0;
        mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = wdata;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (c > 0 && !mem_stall) begin
                done = 1;
                o_din = mem_din; o_err = mem_err; o_addr_done = ram_addr;
            end else begin
                if (mem_stall) o_stall++;
                if (ram_cs) begin
                    o_cs++; o_cs_cyc = cyc; o_addr = ram_addr; o_we = ram_we; o_wdata = ram_wdata;
                    waitn = 0;
                end else if (waitn >= 0) begin
                    waitn++;
                end
                ram_ack   = (waitn >= 0) && (waitn == delay);
                ram_rdata = ram_ack ? rdata : $urandom;
            end
            @(posedge clk); #1;
            ram_ack = 1'b0;
            if (!hold) begin mem_ren = 1'b0; mem_wen = 1'b0; end
        end
        o_timed_out = !done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ren = 1'b1; mem_addr = 32'h44;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", mem_stall); else n_pass++;
        n_checks++; if (mem_din !== 32'd0) $display("FAIL reset_din: got %h want 0", mem_din); else n_pass++;
        n_checks++; if (mem_err !== 1'b0) $display("FAIL reset_err: got %b want 0", mem_err); else n_pass++;
        n_checks++; if ({ram_cs, ram_we} !== 2'b00) $display("FAIL reset_cs_we: got %b want 00", {ram_cs, ram_we}); else n_pass++;
        n_checks++; if (ram_addr !== '0) $display("FAIL reset_addr: got %h want 0", ram_addr); else n_pass++;
        n_checks++; if (ram_wdata !== 32'd0) $display("FAIL reset_wdata: got %h want 0", ram_wdata); else n_pass++;
        mem_ren = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_din = 32'd0; m_err = 1'b0;
    endtask

    task automatic test_read_zero_wait();
        drive_access(1'b1, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 0, 1'b0);
        m_din = 32'h1234_5678;
        n_checks++; if (o_timed_out !== 1'b0) $display("FAIL rd0_budget: access never completed"); else n_pass++;
        n_checks++; if (o_addr !== 10'd4) $display("FAIL rd0_addr: got %0d want 4", o_addr); else n_pass++;
        n_checks++; if (o_we !== 1'b0) $display("FAIL rd0_we: got %b want 0", o_we); else n_pass++;
        n_checks++; if (o_cs !== 1) $display("FAIL rd0_cs_pulses: got %0d want 1", o_cs); else n_pass++;
        n_checks++; if (o_stall !== 2) $display("FAIL rd0_stall: got %0d want 2", o_stall); else n_pass++;
        n_checks++; if (o_din !== 32'h1234_5678) $display("FAIL rd0_din: got %h want 12345678", o_din); else n_pass++;
        n_checks++; if (o_err !== 1'b0) $display("FAIL rd0_err: got %b want 0", o_err); else n_pass++;
    endtask

    task automatic test_write_wait();
        drive_access(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 32'h0BAD_0BAD, 3, 1'b0);
        n_checks++; if (o_cs !== 1) $display("FAIL wr3_cs_pulses: got %0d want 1", o_cs); else n_pass++;
        n_checks++; if (o_we !== 1'b1) $display("FAIL wr3_we: got %b want 1", o_we); else n_pass++;
        n_checks++; if (o_wdata !== 32'hCAFE_F00D) $display("FAIL wr3_wdata: got %h want cafef00d", o_wdata); else n_pass++;
        n_checks++; if (o_stall !== 5) $display("FAIL wr3_stall: got %0d want 5", o_stall); else n_pass++;
        n_checks++; if (o_din !== m_din) $display("FAIL wr3_din_kept: got %h want %h", o_din, m_din); else n_pass++;
        n_checks++; if (o_addr_done !== 10'd8) $display("FAIL wr3_addr_hold: got %0d want 8", o_addr_done); else n_pass++;
    endtask

    task automatic test_stray_ack();
        for (int i = 0; i < 3; i++) begin
            ram_ack = 1'b1; ram_rdata = $urandom;
            @(negedge clk);
            n_checks++; if ({mem_stall, ram_cs} !== 2'b00) $display("FAIL stray_ack_idle: stall,cs got %b want 00", {mem_stall, ram_cs}); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (mem_din !== m_din) $display("FAIL stray_ack_din: got %h want %h", mem_din, m_din); else n_pass++;
        end
        ram_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        int first_cs;
        drive_access(1'b1, 1'b0, 32'h100, 32'h0, 32'h1111_2222, 0, 1'b1);
        first_cs = o_cs_cyc;
        n_checks++; if (o_cs !== 1 || o_stall !== 2) $display("FAIL b2b_first: cs %0d stall %0d want 1 and 2", o_cs, o_stall); else n_pass++;
        n_checks++; if (o_din !== 32'h1111_2222) $display("FAIL b2b_first_din: got %h want 11112222", o_din); else n_pass++;
        drive_access(1'b1, 1'b0, 32'h104, 32'h0, 32'h3333_4444, 0, 1'b0);
        m_din = 32'h3333_4444;
        n_checks++; if (o_cs !== 1 || o_stall !== 2) $display("FAIL b2b_second: cs %0d stall %0d want 1 and 2", o_cs, o_stall); else n_pass++;
        n_checks++; if (o_cs_cyc - first_cs !== 3) $display("FAIL b2b_spacing: got %0d cycles want 3", o_cs_cyc - first_cs); else n_pass++;
        n_checks++; if (o_din !== 32'h3333_4444 || o_addr !== 10'd65) $display("FAIL b2b_second_data: din %h addr %0d want 33334444 and 65", o_din, o_addr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        mem_ren = 1'b1; mem_addr = 32'h40;
        @(posedge clk); #1;
        mem_ren = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL rstmid_stall_low: got %b want 0", mem_stall); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1; ram_ack = 1'b1; ram_rdata = 32'h55AA_55AA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if ({mem_stall, ram_cs, mem_err} !== 3'b000 || mem_din !== 32'd0)
                $display("FAIL rstmid_late_ack: stall,cs,err %b din %h want 000 and 0", {mem_stall, ram_cs, mem_err}, mem_din);
            else n_pass++;
            @(posedge clk); #1;
        end
        ram_ack = 1'b0;
        m_din = 32'd0; m_err = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int op, delay, e_stall, e_cs;
            logic ren, wen, misal, timed;
            logic [31:0] addr, wdata, rdata;
            op = $urandom_range(0, 3);
            ren = (op != 2); wen = (op >= 2);
            addr = $urandom; wdata = $urandom; rdata = $urandom;
            delay = $urandom_range(0, TIMEOUT + 2);
`ifdef DMEM_ALIGN_CHECK_EN
            misal = (addr[1:0] != 2'b00);
`else
            misal = 1'b0;
`endif
            timed = (delay > TIMEOUT);
            if (ren && wen) m_err = 1'b1;
            if (misal) begin
                e_stall = 1; e_cs = 0; m_err = 1'b1;
                if (!wen) m_din = 32'd0;
            end else begin
                e_cs = 1;
                e_stall = 2 + (timed ? TIMEOUT : delay);
                if (timed) begin m_din = 32'hDEAD_BEEF; m_err = 1'b1; end
                else if (!wen) m_din = rdata;
            end
            drive_access(ren, wen, addr, wdata, rdata, delay, 1'b0);
            n_checks++; if (o_timed_out !== 1'b0) $display("FAIL rnd%0d_budget: access never completed", i); else n_pass++;
            n_checks++; if (o_stall !== e_stall) $display("FAIL rnd%0d_stall: got %0d want %0d", i, o_stall, e_stall); else n_pass++;
            n_checks++; if (o_cs !== e_cs) $display("FAIL rnd%0d_cs_pulses: got %0d want %0d", i, o_cs, e_cs); else n_pass++;
            n_checks++; if (o_din !== m_din) $display("FAIL rnd%0d_din: got %h want %h", i, o_din, m_din); else n_pass++;
            n_checks++; if (o_err !== m_err) $display("FAIL rnd%0d_err: got %b want %b", i, o_err, m_err); else n_pass++;
            if (e_cs == 1) begin
                n_checks++; if (o_addr !== addr[ADDR_W+1:2] || o_we !== wen || o_wdata !== wdata)
                    $display("FAIL rnd%0d_ram_req: addr %h we %b wdata %h want %h %b %h", i, o_addr, o_we, o_wdata, addr[ADDR_W+1:2], wen, wdata);
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        drive_access(1'b1, 1'b0, 32'h30, 32'h0, 32'h7777_7777, TIMEOUT + 3, 1'b0);
        n_checks++; if (o_stall !== 2 + TIMEOUT) $display("FAIL to_stall: got %0d want %0d", o_stall, 2 + TIMEOUT); else n_pass++;
        n_checks++; if (o_din !== 32'hDEAD_BEEF) $display("FAIL to_din: got %h want deadbeef", o_din); else n_pass++;
        n_checks++; if (o_err !== 1'b1) $display("FAIL to_err: got %b want 1", o_err); else n_pass++;
        drive_access(1'b1, 1'b0, 32'h34, 32'h0, 32'h0102_0304, TIMEOUT, 1'b0);
        n_checks++; if (o_din !== 32'h0102_0304 || o_stall !== 2 + TIMEOUT) $display("FAIL to_last_wait_ack: din %h stall %0d want 01020304 and %0d", o_din, o_stall, 2 + TIMEOUT); else n_pass++;
        n_checks++; if (o_err !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", o_err); else n_pass++;
    endtask

`ifdef DMEM_ALIGN_CHECK_EN
    task automatic test_misalign();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_access(1'b1, 1'b0, 32'h10, 32'h0, 32'hA5A5_A5A5, 0, 1'b0);
        drive_access(1'b1, 1'b0, 32'h13, 32'h0, 32'h5A5A_5A5A, 0, 1'b0);
        n_checks++; if (o_cs !== 0) $display("FAIL mis_cs: got %0d want 0", o_cs); else n_pass++;
        n_checks++; if (o_stall !== 1) $display("FAIL mis_stall: got %0d want 1", o_stall); else n_pass++;
        n_checks++; if (o_din !== 32'd0) $display("FAIL mis_din: got %h want 0", o_din); else n_pass++;
        n_checks++; if (o_err !== 1'b1) $display("FAIL mis_err: got %b want 1", o_err); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_stray_ack();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_timeout();
`ifdef DMEM_ALIGN_CHECK_EN
        test_misalign();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
